// File: rtl/demux_1to4_if.sv
// Bus for the 1-to-4 registered demultiplexer: one data/select source, four data sinks.
// No handshake: the source drives i and {s1,s0} every cycle and the DUT always accepts them.
interface demux_1to4_if #(
    parameter int DATA_W = 1
) ();
    logic [DATA_W-1:0] i;
    logic              s1;
    logic              s0;
    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y2;
    logic [DATA_W-1:0] y3;

    modport master (
        output i,
        output s1,
        output s0,
        input  y0,
        input  y1,
        input  y2,
        input  y3
    );

    modport slave (
        input  i,
        input  s1,
        input  s0,
        output y0,
        output y1,
        output y2,
        output y3
    );
endinterface

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: i is steered to y[{s1,s0}] one cycle later, others forced to 0.
// Outputs come straight from flops, so there is no combinational input-to-output path.
module demux_1to4 #(
    parameter int DATA_W = 1
) (
    input logic         clk,
    input logic         rst,
    demux_1to4_if.slave bus
);

    logic [1:0]        sel;
    logic [DATA_W-1:0] y_next [4];
    logic [DATA_W-1:0] y_q    [4];

    assign sel = {bus.s1, bus.s0};

    // Every lane defaults to zero, so a select change clears the old lane on the same edge.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            y_next[k] = '0;
        end
        y_next[sel] = bus.i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= y_next[k];
            end
        end
    end

    assign bus.y0 = y_q[0];
    assign bus.y1 = y_q[1];
    assign bus.y2 = y_q[2];
    assign bus.y3 = y_q[3];

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4: a 1-bit and an 8-bit instance share clock and reset.
module tb_demux_1to4;

  logic clk;
  logic rst;

  int total_checks;
  int passed_checks;

  demux_1to4_if #(.DATA_W(1)) bus1 ();
  demux_1to4_if #(.DATA_W(8)) bus8 ();

  demux_1to4 #(.DATA_W(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  demux_1to4 #(.DATA_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  // clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // 1-bit instance: exp is the required {y3,y2,y1,y0}
  task automatic check1(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus1.y3, bus1.y2, bus1.y1, bus1.y0}, {28'd0, exp});
  endtask

  // 8-bit instance: lane sel must hold val, every other lane 0; also one-hot check
  task automatic check8(input string tag, input int sel, input logic [7:0] val);
    logic [31:0] exp_word;
    int nonzero;
    exp_word = 32'd0;
    exp_word[sel*8 +: 8] = val;
    chk(tag, {bus8.y3, bus8.y2, bus8.y1, bus8.y0}, exp_word);
    nonzero = 0;
    if (bus8.y0 != 8'd0) nonzero++;
    if (bus8.y1 != 8'd0) nonzero++;
    if (bus8.y2 != 8'd0) nonzero++;
    if (bus8.y3 != 8'd0) nonzero++;
    chk({tag, "_onehot"}, 32'(nonzero <= 1), 32'd1);
  endtask

  task automatic drive1(input logic i, input logic [1:0] sel);
    bus1.i  = i;
    bus1.s1 = sel[1];
    bus1.s0 = sel[0];
  endtask

  task automatic drive8(input logic [7:0] i, input logic [1:0] sel);
    bus8.i  = i;
    bus8.s1 = sel[1];
    bus8.s0 = sel[0];
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;

    // test 1: reset clears outputs without an edge, holds until first edge after release
    rst = 1'b1;
    drive1(1'b1, 2'b11);
    drive8(8'hA5, 2'b11);
    #2;
    check1("rst_no_edge", 4'b0000);
    check8("rst_no_edge8", 3, 8'h00);
    step();
    check1("rst_held_edge", 4'b0000);
    rst = 1'b0;
    #1;
    check1("rst_released_pre_edge", 4'b0000);
    check8("rst_released_pre_edge8", 3, 8'h00);
    step();
    check1("first_edge_sel3", 4'b1000);
    check8("first_edge_sel3_8", 3, 8'hA5);

    // test 2: i=1 walked through every select, two cycles each
    drive8(8'h00, 2'b00);
    drive1(1'b1, 2'b00);
    step(); check1("walk_sel0_a", 4'b0001);
    step(); check1("walk_sel0_b", 4'b0001);
    drive1(1'b1, 2'b01);
    step(); check1("walk_sel1_a", 4'b0010);
    step(); check1("walk_sel1_b", 4'b0010);
    drive1(1'b1, 2'b10);
    step(); check1("walk_sel2_a", 4'b0100);
    step(); check1("walk_sel2_b", 4'b0100);
    drive1(1'b1, 2'b11);
    step(); check1("walk_sel3_a", 4'b1000);
    step(); check1("walk_sel3_b", 4'b1000);

    // test 3: i=0 gives all-zero outputs for every select
    drive1(1'b0, 2'b00); step(); check1("zero_sel0", 4'b0000);
    drive1(1'b0, 2'b01); step(); check1("zero_sel1", 4'b0000);
    drive1(1'b0, 2'b10); step(); check1("zero_sel2", 4'b0000);
    drive1(1'b0, 2'b11); step(); check1("zero_sel3", 4'b0000);

    // test 4: sel=01, i toggling 1,0,1
    drive1(1'b1, 2'b01); step(); check1("toggle_1", 4'b0010);
    drive1(1'b0, 2'b01); step(); check1("toggle_0", 4'b0000);
    drive1(1'b1, 2'b01); step(); check1("toggle_1b", 4'b0010);

    // test 5: asynchronous reset between edges
    drive1(1'b1, 2'b10);
    step(); check1("async_settled", 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check1("async_cleared", 4'b0000);
    #1;
    rst = 1'b0;
    #1;
    check1("async_released_pre_edge", 4'b0000);
    step(); check1("async_reload", 4'b0100);

    // test 6: 8-bit copy and one-hot on every cycle
    drive8(8'hA5, 2'b11); step(); check8("w8_a5_sel3", 3, 8'hA5);
    drive8(8'h3C, 2'b00); step(); check8("w8_3c_sel0", 0, 8'h3C);
    drive8(8'hFF, 2'b01); step(); check8("w8_ff_sel1", 1, 8'hFF);
    drive8(8'h5A, 2'b10); step(); check8("w8_5a_sel2", 2, 8'h5A);
    drive8(8'h81, 2'b10); step(); check8("w8_81_sel2", 2, 8'h81);
    drive8(8'h00, 2'b11); step(); check8("w8_00_sel3", 3, 8'h00);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
